// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: memory opcodes, access size and the load/store decode.
package mips_defs;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic  is_load;
    logic  is_store;
    logic  sext;
    size_e size;
  } mem_op_t;

  // Non-memory opcodes decode to WORD with both strobes low so the
  // alignment logic stays well defined but never takes effect.
  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d = '{is_load: 1'b0, is_store: 1'b0, sext: 1'b0, size: WORD};
    case (op)
      OP_LW:  d = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b0, size: WORD};
      OP_LH:  d = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b1, size: HALF};
      OP_LHU: d = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b0, size: HALF};
      OP_LB:  d = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b1, size: BYTE};
      OP_LBU: d = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b0, size: BYTE};
      OP_SW:  d = '{is_load: 1'b0, is_store: 1'b1, sext: 1'b0, size: WORD};
      OP_SH:  d = '{is_load: 1'b0, is_store: 1'b1, sext: 1'b0, size: HALF};
      OP_SB:  d = '{is_load: 1'b0, is_store: 1'b1, sext: 1'b0, size: BYTE};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/m_dmem_lane.sv
// Byte-lane steering: store mask and shifted store data, plus load extraction
// with sign or zero extension. Purely combinational.
module dm_lane
  import mips_defs::*;
(
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] mask,
  output logic [31:0] wshift,
  output logic [31:0] ldata
);

  logic [4:0]  shamt;
  logic [31:0] rsh;

  assign shamt = {lane, 3'b000};

  // Build the lane mask/shifted data and extract the addressed load bytes.
  always_comb begin
    mask   = '0;
    wshift = '0;
    ldata  = '0;
    rsh    = rword >> shamt;
    case (size)
      BYTE: begin
        mask   = 32'h0000_00ff << shamt;
        wshift = {24'b0, wdata[7:0]} << shamt;
        ldata  = sext ? {{24{rsh[7]}}, rsh[7:0]} : {24'b0, rsh[7:0]};
      end
      HALF: begin
        mask   = 32'h0000_ffff << shamt;
        wshift = {16'b0, wdata[15:0]} << shamt;
        ldata  = sext ? {{16{rsh[15]}}, rsh[15:0]} : {16'b0, rsh[15:0]};
      end
      WORD: begin
        mask   = 32'hffff_ffff;
        wshift = wdata;
        ldata  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/m_dmem.sv
// M-stage data memory: opcode decode, align/range check, read-modify-write
// store port, combinational extended load path and the store log.
module m_dmem
  import mips_defs::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter bit LOG_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] rd2M,
  input  logic [31:0] PCM,
  output logic [31:0] rdataM,
  output logic        addrErrM,
  output logic        storeM
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  mem_op_t     op;
  logic        is_mem;
  logic        misaligned;
  logic        out_of_range;
  logic [AW-1:0] idx;
  logic [31:0] rword;
  logic [31:0] mask;
  logic [31:0] wshift;
  logic [31:0] ldata;
  logic [31:0] merged;
  logic        unused_bits;

  assign op           = decode_op(instrM[31:26]);
  assign is_mem       = op.is_load | op.is_store;
  assign out_of_range = (ALUOutM >= BYTE_LIMIT);
  assign idx          = ALUOutM[AW+1:2];
  assign unused_bits  = ^instrM[25:0];

  // Alignment requirement depends on access size.
  always_comb begin
    misaligned = 1'b0;
    case (op.size)
      HALF:    misaligned = ALUOutM[0];
      WORD:    misaligned = |ALUOutM[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Out-of-range addresses never touch the array, so they cannot alias.
  assign rword    = out_of_range ? 32'h0 : mem[idx];
  assign addrErrM = is_mem & (misaligned | out_of_range);
  assign storeM   = op.is_store & ~addrErrM;
  assign merged   = (rword & ~mask) | (wshift & mask);
  assign rdataM   = (op.is_load & ~addrErrM) ? ldata : 32'h0;

  dm_lane u_lane (
    .lane   (ALUOutM[1:0]),
    .size   (op.size),
    .sext   (op.sext),
    .wdata  (rd2M),
    .rword  (rword),
    .mask   (mask),
    .wshift (wshift),
    .ldata  (ldata)
  );

  // Array: cleared on reset, otherwise written with the merged word on a committed store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (storeM) begin
      mem[idx] <= merged;
    end
  end

`ifndef SYNTHESIS
  // Store log; a store on a reset edge is dropped and so is not logged.
  always_ff @(posedge clk) begin
    if (LOG_EN && !reset && storeM)
      $display("@%h: *%h <= %h", PCM, {ALUOutM[31:2], 2'b00}, merged);
  end
`endif

endmodule
